// File: rtl/bip_pkg.sv
// Shared BIP1 definitions: ISA opcodes, exec-controller state encoding and
// result-frame sizing.
package bip_pkg;

  // BIP1 ISA opcodes. The instruction decoder uses the same constants.
  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  // Execution controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } exec_state_e;

  // Frame length: status byte, then accumulator bytes, then counter bytes.
  function automatic int frame_bytes(input int nb_data, input int nb_cyc);
    return 1 + nb_data / 8 + nb_cyc / 8;
  endfunction

  localparam int FRAME_BYTES = frame_bytes(16, 16);

endpackage

// File: rtl/result_frame_tx.sv
// Result snapshot registers plus a valid/ready byte serializer.
// Handshake: o_tx_valid is high for the whole frame; a byte moves on any
// edge where o_tx_valid and i_tx_ready are both high, and o_tx_data holds
// its value until that happens.
module result_frame_tx
  import bip_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_CYC  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_flag,
  input  logic              i_capture,
  input  logic              i_timeout,
  input  logic [NB_DATA-1:0] i_acc,
  input  logic [NB_CYC-1:0] i_cnt,
  input  logic              i_send,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  output logic              o_last_byte_done
);

  localparam int NB    = frame_bytes(NB_DATA, NB_CYC);
  localparam int IDX_W = $clog2(NB);

  logic               timeout_q, timeout_d;
  logic [NB_DATA-1:0] acc_q, acc_d;
  logic [NB_CYC-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NB*8-1:0]    frame;
  logic               xfer;
  logic               last_idx;

  assign frame      = {7'b0, timeout_q, acc_q, cnt_q};
  assign xfer       = i_send & i_tx_ready;
  assign last_idx   = (idx_q == IDX_W'(NB - 1));
  assign o_tx_valid = i_send;
  assign o_last_byte_done = xfer & last_idx;

  // Snapshot load on capture, index advance on each accepted byte.
  always_comb begin
    timeout_d = timeout_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (i_clr_flag) begin
      timeout_d = 1'b0;
    end
    if (i_capture) begin
      timeout_d = i_timeout;
      acc_d     = i_acc;
      cnt_d     = i_cnt;
      idx_d     = '0;
    end else if (xfer) begin
      idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Byte select, MSB-first through the frame vector.
  always_comb begin
    o_tx_data = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (idx_q == IDX_W'(b)) o_tx_data = frame[(NB-1-b)*8 +: 8];
    end
  end

  // Snapshot and index registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      timeout_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      timeout_q <= timeout_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: rtl/bip_exec_ctrl.sv
// BIP1 execution sequencer: clear, run until HALT or watchdog, then stream
// the {timeout, acc, count} result frame to the UART TX.
module bip_exec_ctrl
  import bip_pkg::*;
#(
  parameter int                 NB_OPCODE   = 5,
  parameter int                 NB_DATA     = 16,
  parameter int                 NB_CYC      = 16,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = OP_HLT,
  parameter logic [NB_CYC-1:0]  MAX_CYCLES  = 16'hFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_DATA-1:0]   i_acc,
  input  logic                 i_tx_ready,
  output logic                 o_cpu_clr,
  output logic                 o_cpu_en,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output exec_state_e          o_dbg_state
);

  exec_state_e       state_q, state_d;
  logic [NB_CYC-1:0] cnt_q, cnt_d;
  logic              capture;
  logic              timeout;
  logic              last_byte_done;
  logic              is_halt;
  logic              at_max;

  assign is_halt     = (i_opcode == HALT_OPCODE);
  assign at_max      = (cnt_q == MAX_CYCLES);
  assign o_dbg_state = state_q;

  // Next state, counter and outputs. HALT has priority over the watchdog,
  // and the HALT instruction itself is never enabled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_cpu_clr = 1'b0;
    o_cpu_en  = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        o_cpu_clr = 1'b1;
        o_busy    = 1'b1;
        cnt_d     = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        o_busy   = 1'b1;
        o_cpu_en = !is_halt && !at_max;
        if (o_cpu_en) cnt_d = cnt_q + NB_CYC'(1);
        if (is_halt) begin
          capture = 1'b1;
          state_d = ST_SEND;
        end else if (at_max) begin
          capture = 1'b1;
          timeout = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        o_busy = 1'b1;
        if (last_byte_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and instruction counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  result_frame_tx #(
    .NB_DATA(NB_DATA),
    .NB_CYC (NB_CYC)
  ) u_frame (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clr_flag      (o_cpu_clr),
    .i_capture       (capture),
    .i_timeout       (timeout),
    .i_acc           (i_acc),
    .i_cnt           (cnt_q),
    .i_send          (state_q == ST_SEND),
    .i_tx_ready      (i_tx_ready),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .o_last_byte_done(last_byte_done)
  );

endmodule
